// File: rtl/aes256_byte_collector.sv
// Drains one 16-byte ciphertext block from an upstream byte source and presents it as 128 bits.
// Optional block counter port enabled by defining AES256_COLLECTOR_CNT_EN.
module aes256_byte_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pi_enc_done,
    output logic         po_next_val_req,
    input  logic         pi_next_val_ready,
    input  logic [7:0]   pi_data,
    output logic [127:0] po_block,
    output logic         po_block_valid,
    input  logic         pi_block_ready,
    output logic         po_busy,
    output logic         po_timeout,
`ifdef AES256_COLLECTOR_CNT_EN
    output logic [15:0]  po_block_count,
`endif
    output logic         po_overrun
);

    typedef enum logic [2:0] {StIdle, StReq, StGap, StOut, StErr} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    wait_q, wait_d;
    logic           pending_q, pending_d;
    logic           overrun_q, overrun_d;
    logic [127:0]   block_q, block_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            wait_q    <= 16'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            block_q   <= 128'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            block_q   <= block_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        block_d   = block_q;

        // A done seen while IDLE is consumed by the IDLE exit itself.
        if (pi_enc_done && (state_q != StIdle)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (pi_enc_done || pending_q) begin
                    state_d   = StReq;
                    cnt_d     = 4'd0;
                    wait_d    = 16'd0;
                    pending_d = 1'b0;
                end
            end
            StReq: begin
                if (pi_next_val_ready) begin
                    // Byte 0 lands in the most significant byte.
                    block_d[{4'd15 - cnt_q, 3'b000} +: 8] = pi_data;
                    if (cnt_q == 4'd15) begin
                        state_d = StOut;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = StGap;
                    end
                end else if (wait_q == TimeoutLast) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            StGap: begin
                state_d = StReq;
                wait_d  = 16'd0;
            end
            StOut: begin
                if (pi_block_ready) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    assign po_next_val_req = (state_q == StReq);
    assign po_block_valid  = (state_q == StOut);
    assign po_busy         = (state_q != StIdle);
    assign po_timeout      = (state_q == StErr);
    assign po_overrun      = overrun_q;
    assign po_block        = block_q;

`ifdef AES256_COLLECTOR_CNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
        end else if ((state_q == StOut) && pi_block_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign po_block_count = count_q;
`endif

endmodule
